binary_frame_ctrl: RTL and testbench

BINARY_FRAME_CTRL -- requirements
Module: binary_frame_ctrl

---
 rtl/binary_pkg.sv | 31 +++
 rtl/binary_skid.sv | 60 ++++++
 rtl/binary_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_binary_frame_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_pkg.sv
// Shared types and constants for the binary frame controller.
// Provides the pixel width, binarized levels, FSM state type and output beat payload.
package binary_pkg;

  localparam int unsigned PIX_W = 8;
  localparam logic [PIX_W-1:0] BIN_HI     = 8'd255;
  localparam logic [PIX_W-1:0] BIN_LO     = 8'd0;
  localparam logic [PIX_W-1:0] THRESH_RST = 8'd128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic             sof;
    logic             eol;
  } pix_beat_t;

  // Midpoint of two gray levels, summed at PIX_W+1 bits so the carry is kept.
  function automatic logic [PIX_W-1:0] mid_thresh(input logic [PIX_W-1:0] lo,
                                                  input logic [PIX_W-1:0] hi);
    logic [PIX_W:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[PIX_W:1];
  endfunction

endpackage

// File: rtl/binary_skid.sv
// Two-entry valid/ready skid buffer for binarized pixel beats.
// Upstream guarantees a push never arrives while both entries are held without a pop.
module binary_skid
  import binary_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  pix_beat_t  in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output pix_beat_t  out_data,
  output logic [1:0] count
);

  localparam int unsigned CNT_W = 2;

  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             vld_q;
  pix_beat_t        e0_q, e0_n, e1_q, e1_n;
  logic             pop;

  // Entry 0 always drives the output; entry 1 catches the beat that arrives during a stall.
  always_comb begin
    pop   = vld_q && out_ready;
    e0_n  = e0_q;
    e1_n  = e1_q;
    cnt_n = cnt_q + CNT_W'(in_valid) - CNT_W'(pop);
    if (pop) begin
      if (cnt_q == 2'd2) begin
        e0_n = e1_q;
        if (in_valid) e1_n = in_data;
      end else if (in_valid) begin
        e0_n = in_data;
      end
    end else if (in_valid) begin
      if (cnt_q == 2'd0) e0_n = in_data;
      else               e1_n = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_n;
      vld_q <= (cnt_n != '0);
      e0_q  <= e0_n;
      e1_q  <= e1_n;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = e0_q;
  assign count     = cnt_q;

endmodule

// File: rtl/binary_frame_ctrl.sv
// Streams a gray frame from memory in raster order and emits thresholded pixels.
// Define BINARY_AUTO_THRESH_EN to derive each frame's threshold from the previous frame's min/max.
module binary_frame_ctrl
  import binary_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [PIX_W-1:0]                    thresh,
  output logic                                rd_en,
  output logic [$clog2(IMG_W*IMG_H)-1:0]      rd_addr,
  input  logic [PIX_W-1:0]                    rd_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PIX_W-1:0]                    out_pixel,
  output logic                                out_sof,
  output logic                                out_eol,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = $clog2(NPIX);
  localparam int unsigned COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [COL_W-1:0]  col_q, col_n;
  logic [PIX_W-1:0]  thr_q, thr_n, start_thr;
  logic              pend_q, pend_sof_q, pend_eol_q;
  logic              busy_q, done_q;
  logic              credit_ok, pop;
  logic [1:0]        sk_count;
  logic              sk_valid;
  pix_beat_t         sk_in, sk_out;

`ifdef BINARY_AUTO_THRESH_EN
  logic [PIX_W-1:0] min_q, max_q, auto_thr_q;
  logic             have_stats_q;

  assign start_thr = have_stats_q ? auto_thr_q : thresh;

  // Statistics of the frame in flight; only a completed frame publishes its midpoint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q        <= BIN_HI;
      max_q        <= BIN_LO;
      auto_thr_q   <= THRESH_RST;
      have_stats_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        min_q <= BIN_HI;
        max_q <= BIN_LO;
      end else if (pend_q) begin
        if (rd_data < min_q) min_q <= rd_data;
        if (rd_data > max_q) max_q <= rd_data;
      end
      if (state_q == DONE) begin
        auto_thr_q   <= mid_thresh(min_q, max_q);
        have_stats_q <= 1'b1;
      end
    end
  end
`else
  assign start_thr = thresh;
`endif

  assign pop = sk_valid && out_ready;
  // Skid entries plus reads in flight must fit in two slots, crediting a pop this cycle.
  assign credit_ok = ({1'b0, sk_count} + 3'(pend_q)) <= (3'd1 + 3'(pop));

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    col_n   = col_q;
    thr_n   = thr_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          addr_n  = '0;
          col_n   = '0;
          thr_n   = start_thr;
        end
      end
      RUN: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          col_n = (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
          if (addr_q == LAST_ADDR) begin
            state_n = FLUSH;
            addr_n  = '0;
          end else begin
            addr_n = addr_q + ADDR_W'(1);
          end
        end
      end
      FLUSH: begin
        if (pop && sk_count == 2'd1 && !pend_q) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      thr_q      <= THRESH_RST;
      pend_q     <= 1'b0;
      pend_sof_q <= 1'b0;
      pend_eol_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      addr_q     <= addr_n;
      col_q      <= col_n;
      thr_q      <= thr_n;
      pend_q     <= rd_en;
      pend_sof_q <= rd_en && (addr_q == '0);
      pend_eol_q <= rd_en && (col_q == LAST_COL);
      busy_q     <= (state_n != IDLE);
      done_q     <= (state_n == DONE);
    end
  end

  always_comb begin
    sk_in       = '0;
    sk_in.pixel = (rd_data >= thr_q) ? BIN_HI : BIN_LO;
    sk_in.sof   = pend_sof_q;
    sk_in.eol   = pend_eol_q;
  end

  binary_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pend_q),
    .in_data   (sk_in),
    .out_valid (sk_valid),
    .out_ready (out_ready),
    .out_data  (sk_out),
    .count     (sk_count)
  );

  assign rd_addr   = addr_q;
  assign out_valid = sk_valid;
  assign out_pixel = sk_out.pixel;
  assign out_sof   = sk_out.sof;
  assign out_eol   = sk_out.eol;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_binary_frame_ctrl.sv
// Directed bench for binary_frame_ctrl: a 4x2 instance for exact vectors and a 16x16 instance
// for random back-pressure. Scenarios gated on BINARY_AUTO_THRESH_EN follow the build.
module tb_binary_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [7:0] thresh = 8'd0;
  logic       out_ready = 1'b0;

  logic       start_a = 1'b0, rd_en_a, out_valid_a, out_sof_a, out_eol_a, busy_a, done_a;
  logic [2:0] rd_addr_a;
  logic [7:0] rd_data_a = 8'd0, out_pixel_a;
  logic       start_b = 1'b0, rd_en_b, out_valid_b, out_sof_b, out_eol_b, busy_b, done_b;
  logic [7:0] rd_addr_b;
  logic [7:0] rd_data_b = 8'd0, out_pixel_b;

  logic [7:0] mem_a [8];
  logic [7:0] mem_b [256];

  int errors = 0;
  int checks = 0;

  logic [7:0] gpix [$];
  logic       gsof [$];
  logic       geol [$];

  binary_frame_ctrl #(.IMG_W(4), .IMG_H(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .thresh(thresh),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_pixel(out_pixel_a),
    .out_sof(out_sof_a), .out_eol(out_eol_a), .busy(busy_a), .done(done_a)
  );

  binary_frame_ctrl #(.IMG_W(16), .IMG_H(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .thresh(thresh),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pixel(out_pixel_b),
    .out_sof(out_sof_b), .out_eol(out_eol_b), .busy(busy_b), .done(done_b)
  );

  // Gray memories with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
  end

  task automatic do_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_a(input logic [7:0] v0, v1, v2, v3, v4, v5, v6, v7);
    mem_a[0] = v0; mem_a[1] = v1; mem_a[2] = v2; mem_a[3] = v3;
    mem_a[4] = v4; mem_a[5] = v5; mem_a[6] = v6; mem_a[7] = v7;
  endtask

  // Runs one frame on the 4x2 instance, capturing transfers and timing; optionally pokes start.
  task automatic run_a(input bit poke, output int ndone, output int first_rd,
                       output int first_vld, output int last_x, output bit tmo);
    int done_c;
    gpix.delete(); gsof.delete(); geol.delete();
    ndone = 0; first_rd = -1; first_vld = -1; last_x = -1; tmo = 1'b1; done_c = -1;
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (rd_en_a && first_rd < 0) first_rd = c;
      if (out_valid_a && first_vld < 0) first_vld = c;
      if (out_valid_a && out_ready) begin
        gpix.push_back(out_pixel_a); gsof.push_back(out_sof_a); geol.push_back(out_eol_a);
        last_x = c;
      end
      if (done_a) begin ndone++; if (done_c < 0) done_c = c; end
      if (done_c >= 0 && c >= done_c + 4) begin tmo = 1'b0; break; end
      start_a = poke && busy_a && !done_a && (c % 3 == 1);
      @(posedge clk); #1;
    end
    start_a = 1'b0;
  endtask

  task automatic check_frame_a(input string tag, input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    logic [7:0] exp_pix [8];
    exp_pix[0] = e0; exp_pix[1] = e1; exp_pix[2] = e2; exp_pix[3] = e3;
    exp_pix[4] = e4; exp_pix[5] = e5; exp_pix[6] = e6; exp_pix[7] = e7;
    checks++;
    if (gpix.size() !== 8) begin
      errors++; $display("FAIL %s count: got %0d want 8", tag, gpix.size());
    end
    for (int i = 0; i < 8 && i < gpix.size(); i++) begin
      checks++;
      if (gpix[i] !== exp_pix[i]) begin
        errors++; $display("FAIL %s pixel[%0d]: got %0d want %0d", tag, i, gpix[i], exp_pix[i]);
      end
      checks++;
      if (gsof[i] !== (i == 0)) begin
        errors++; $display("FAIL %s sof[%0d]: got %0b want %0b", tag, i, gsof[i], (i == 0));
      end
      checks++;
      if (geol[i] !== (i == 3 || i == 7)) begin
        errors++; $display("FAIL %s eol[%0d]: got %0b want %0b", tag, i, geol[i], (i == 3 || i == 7));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #1;
    checks++;
    if ({rd_en_a, out_valid_a, out_sof_a, out_eol_a, busy_a, done_a, out_pixel_a, rd_addr_a} !== 17'd0) begin
      errors++; $display("FAIL reset_a: got outputs %h want 0",
                         {rd_en_a, out_valid_a, out_sof_a, out_eol_a, busy_a, done_a, out_pixel_a, rd_addr_a});
    end
    checks++;
    if ({rd_en_b, out_valid_b, out_sof_b, out_eol_b, busy_b, done_b, out_pixel_b, rd_addr_b} !== 22'd0) begin
      errors++; $display("FAIL reset_b: got outputs %h want 0",
                         {rd_en_b, out_valid_b, out_sof_b, out_eol_b, busy_b, done_b, out_pixel_b, rd_addr_b});
    end
    do_reset();
  endtask

  task automatic test_basic();
    int nd, frd, fvl, lx; bit tmo;
    do_reset();
    load_a(8'd10, 8'd100, 8'd128, 8'd200, 8'd255, 8'd99, 8'd0, 8'd101);
    thresh = 8'd100; out_ready = 1'b1;
    run_a(1'b0, nd, frd, fvl, lx, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL basic timeout: got no done want done"); end
    check_frame_a("basic", 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255);
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL basic done_pulses: got %0d want 1", nd); end
    checks++;
    if (fvl - frd !== 2) begin errors++; $display("FAIL latency: got %0d want 2", fvl - frd); end
    checks++;
    if (lx - fvl !== 7) begin errors++; $display("FAIL throughput span: got %0d want 7", lx - fvl); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL basic busy_after: got %0b want 0", busy_a); end
  endtask

  task automatic test_thresh_next_frame();
    int nd, frd, fvl, lx; bit tmo;
    thresh = 8'd200;
    run_a(1'b0, nd, frd, fvl, lx, tmo);
    checks++;
    if (tmo || nd !== 1) begin errors++; $display("FAIL frame2 done: got %0d want 1", nd); end
`ifdef BINARY_AUTO_THRESH_EN
    // Previous frame spanned 0..255, so the midpoint 127 applies regardless of the port.
    check_frame_a("frame2", 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
`else
    check_frame_a("frame2", 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
`endif
  endtask

  task automatic test_busy_start();
    int nd, frd, fvl, lx; bit tmo;
    do_reset();
    load_a(8'd10, 8'd100, 8'd128, 8'd200, 8'd255, 8'd99, 8'd0, 8'd101);
    thresh = 8'd100; out_ready = 1'b1;
    run_a(1'b1, nd, frd, fvl, lx, tmo);
    checks++;
    if (tmo || nd !== 1) begin errors++; $display("FAIL busy_start done: got %0d want 1", nd); end
    check_frame_a("busy_start", 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255);
    checks++;
    if (busy_a !== 1'b0 || rd_en_a !== 1'b0) begin
      errors++; $display("FAIL busy_start restart: got busy=%0b rd_en=%0b want 0 0", busy_a, rd_en_a);
    end
  endtask

  task automatic test_backpressure();
    int nx, na, nd; bit fin;
    logic [7:0] ep;
    do_reset();
    thresh = 8'd128;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
    mem_b[0] = 8'd128; mem_b[1] = 8'd127;
    nx = 0; na = 0; nd = 0; fin = 1'b0;
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (rd_en_b) begin
        checks++;
        if (rd_addr_b !== 8'(na)) begin errors++; $display("FAIL rd_addr: got %0d want %0d", rd_addr_b, na); end
        na++;
      end
      if (out_valid_b) begin
        if (nx >= 256) begin
          checks++; errors++; $display("FAIL extra pixel: got index %0d want <256", nx);
        end else begin
          ep = (mem_b[nx] >= 8'd128) ? 8'd255 : 8'd0;
          checks++;
          if (out_pixel_b !== ep || out_sof_b !== (nx == 0) || out_eol_b !== (nx % 16 == 15)) begin
            errors++;
            $display("FAIL stream[%0d]: got pix=%0d sof=%0b eol=%0b want pix=%0d sof=%0b eol=%0b",
                     nx, out_pixel_b, out_sof_b, out_eol_b, ep, (nx == 0), (nx % 16 == 15));
          end
          if (out_ready) nx++;
        end
      end
      if (done_b) begin nd++; fin = 1'b1; end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (done_b) nd++; end
    checks++;
    if (nx !== 256) begin errors++; $display("FAIL bp transfers: got %0d want 256", nx); end
    checks++;
    if (na !== 256) begin errors++; $display("FAIL bp reads: got %0d want 256", na); end
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL bp done_pulses: got %0d want 1", nd); end
  endtask

  task automatic test_reset_mid();
    int n, nd, frd, fvl, lx; bit tmo;
    do_reset();
    load_a(8'd10, 8'd100, 8'd128, 8'd200, 8'd255, 8'd99, 8'd0, 8'd101);
    thresh = 8'd100; out_ready = 1'b1; n = 0;
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (n == 4) break;
      if (out_valid_a && out_ready) n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 4 || out_valid_a !== 1'b1) begin
      errors++; $display("FAIL mid pre: got n=%0d valid=%0b want 4 1", n, out_valid_a);
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({rd_en_a, out_valid_a, out_sof_a, out_eol_a, busy_a, done_a, out_pixel_a, rd_addr_a} !== 17'd0) begin
      errors++; $display("FAIL mid reset async: got %h want 0",
                         {rd_en_a, out_valid_a, out_sof_a, out_eol_a, busy_a, done_a, out_pixel_a, rd_addr_a});
    end
    @(posedge clk); #1;
    checks++;
    if ({rd_en_a, out_valid_a, out_sof_a, out_eol_a, busy_a, done_a, out_pixel_a, rd_addr_a} !== 17'd0) begin
      errors++; $display("FAIL mid reset edge: got %h want 0",
                         {rd_en_a, out_valid_a, out_sof_a, out_eol_a, busy_a, done_a, out_pixel_a, rd_addr_a});
    end
    rst_n = 1'b1; @(posedge clk); #1;
    run_a(1'b0, nd, frd, fvl, lx, tmo);
    checks++;
    if (tmo || nd !== 1) begin errors++; $display("FAIL mid restart done: got %0d want 1", nd); end
    check_frame_a("mid_restart", 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255);
  endtask

`ifdef BINARY_AUTO_THRESH_EN
  task automatic test_auto_thresh();
    int nd, frd, fvl, lx; bit tmo;
    do_reset();
    out_ready = 1'b1;
    load_a(8'd20, 8'd220, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100);
    thresh = 8'd0;
    run_a(1'b0, nd, frd, fvl, lx, tmo);
    check_frame_a("auto_f1", 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    load_a(8'd119, 8'd120, 8'd20, 8'd220, 8'd119, 8'd120, 8'd0, 8'd255);
    thresh = 8'd250;
    run_a(1'b0, nd, frd, fvl, lx, tmo);
    checks++;
    if (tmo || nd !== 1) begin errors++; $display("FAIL auto_f2 done: got %0d want 1", nd); end
    check_frame_a("auto_f2", 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_thresh_next_frame();
    test_busy_start();
    test_backpressure();
    test_reset_mid();
`ifdef BINARY_AUTO_THRESH_EN
    test_auto_thresh();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
